// File: rtl/uart_dbg_responder.sv
// Target side of the UART debug protocol: decodes host commands from the rx byte
// stream, drives OBI reads/writes and exec requests, and answers over tx.
module uart_dbg_responder #(
    parameter int unsigned TimeoutCycles = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,
    output logic        exec_valid_o,
    output logic [31:0] exec_addr_o,
    input  logic        eoc_i,
    output logic        rx_overrun_o
);
    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam logic [7:0] CmdRead = 8'h11, CmdWrite = 8'h12, CmdExec = 8'h13;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_CNT, S_WDATA, S_WREQ, S_WRSP, S_RREQ, S_RRSP,
        S_RSEND, S_TXACK, S_TXEOT, S_TXNAK, S_TXEOC
    } state_e;

    state_e        state_q;
    logic [7:0]    cmd_q, tx_data_q;
    logic [31:0]   addr_q, wdata_q, rdata_q, obi_addr_q, obi_wdata_q, exec_addr_q;
    logic [1:0]    bcnt_q;
    logic [8:0]    wcnt_q;
    logic [TW-1:0] tmo_q;
    logic          err_q, eoc_pend_q, eoc_prev_q, tx_valid_q, req_q, we_q;
    logic          exec_valid_q, overrun_q;

    logic       wait_st, rx_ok, tmo_hit, last_word, err_nx;
    logic [7:0] rx_b, tx_byte;

    assign wait_st   = (state_q == S_ADDR) || (state_q == S_CNT) || (state_q == S_WDATA);
    assign rx_ok     = wait_st || (state_q == S_IDLE);
    assign tmo_hit   = (tmo_q == TW'(TimeoutCycles - 1));
    assign last_word = (wcnt_q == 9'd1);
    assign err_nx    = err_q | obi_err_i;
    // A0[1:0] are dropped so every address is word aligned.
    assign rx_b      = (bcnt_q == 2'd0) ? {rx_data_i[7:2], 2'b00} : rx_data_i;

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            S_TXACK: tx_byte = 8'h06;
            S_TXEOT: tx_byte = 8'h04;
            S_TXNAK: tx_byte = 8'h15;
            S_TXEOC: tx_byte = 8'h14;
            S_RSEND: tx_byte = rdata_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;      cmd_q <= '0;       addr_q <= '0;
            wdata_q <= '0;          rdata_q <= '0;     bcnt_q <= '0;
            wcnt_q <= '0;           tmo_q <= '0;       err_q <= 1'b0;
            eoc_pend_q <= 1'b0;     eoc_prev_q <= 1'b0;
            tx_valid_q <= 1'b0;     tx_data_q <= '0;   req_q <= 1'b0;
            we_q <= 1'b0;           obi_addr_q <= '0;  obi_wdata_q <= '0;
            exec_valid_q <= 1'b0;   exec_addr_q <= '0; overrun_q <= 1'b0;
        end else begin
            exec_valid_q <= 1'b0;
            eoc_prev_q   <= eoc_i;
            if (rx_valid_i && !rx_ok) overrun_q <= 1'b1;
            tmo_q <= (wait_st && !rx_valid_i) ? tmo_q + 1'b1 : '0;

            case (state_q)
                S_IDLE: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == CmdRead || rx_data_i == CmdWrite || rx_data_i == CmdExec) begin
                            cmd_q   <= rx_data_i;
                            bcnt_q  <= 2'd0;
                            err_q   <= 1'b0;
                            state_q <= S_ADDR;
                        end
                    end else if (eoc_pend_q) begin
                        eoc_pend_q <= 1'b0;
                        state_q    <= S_TXEOC;
                    end
                end
                S_ADDR: begin
                    // EXEC pulses while still in ADDR so the pulse lands the cycle before TXACK.
                    if (exec_valid_q) begin
                        state_q <= S_TXACK;
                    end else if (rx_valid_i) begin
                        addr_q <= {rx_b, addr_q[31:8]};
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            if (cmd_q == CmdExec) begin
                                exec_valid_q <= 1'b1;
                                exec_addr_q  <= {rx_b, addr_q[31:8]};
                            end else begin
                                state_q <= S_CNT;
                            end
                        end
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_CNT: begin
                    if (rx_valid_i) begin
                        wcnt_q  <= (rx_data_i == 8'd0) ? 9'd256 : {1'b0, rx_data_i};
                        bcnt_q  <= 2'd0;
                        state_q <= (cmd_q == CmdRead) ? S_TXACK : S_WDATA;
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WDATA: begin
                    if (rx_valid_i) begin
                        wdata_q <= {rx_data_i, wdata_q[31:8]};
                        bcnt_q  <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            if (err_q) begin
                                addr_q <= addr_q + 32'd4;
                                wcnt_q <= wcnt_q - 9'd1;
                                if (last_word) state_q <= S_TXNAK;
                            end else begin
                                obi_addr_q  <= addr_q;
                                obi_wdata_q <= {rx_data_i, wdata_q[31:8]};
                                state_q     <= S_WREQ;
                            end
                        end
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WREQ: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                        we_q  <= 1'b1;
                    end else if (obi_gnt_i) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_WRSP;
                    end
                end
                S_WRSP: begin
                    if (obi_rvalid_i) begin
                        err_q  <= err_nx;
                        addr_q <= addr_q + 32'd4;
                        wcnt_q <= wcnt_q - 9'd1;
                        if (last_word) state_q <= err_nx ? S_TXNAK : S_TXACK;
                        else           state_q <= S_WDATA;
                    end
                end
                S_RREQ: begin
                    if (!req_q) begin
                        req_q      <= 1'b1;
                        obi_addr_q <= addr_q;
                    end else if (obi_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_RRSP;
                    end
                end
                S_RRSP: begin
                    if (obi_rvalid_i) begin
                        if (obi_err_i) begin
                            state_q <= S_TXNAK;
                        end else begin
                            rdata_q <= obi_rdata_i;
                            bcnt_q  <= 2'd0;
                            state_q <= S_RSEND;
                        end
                    end
                end
                S_RSEND, S_TXACK, S_TXEOT, S_TXNAK, S_TXEOC: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= tx_byte;
                    end else if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        case (state_q)
                            S_RSEND: begin
                                rdata_q <= {8'h00, rdata_q[31:8]};
                                bcnt_q  <= bcnt_q + 2'd1;
                                if (bcnt_q == 2'd3) begin
                                    addr_q  <= addr_q + 32'd4;
                                    wcnt_q  <= wcnt_q - 9'd1;
                                    state_q <= last_word ? S_TXEOT : S_RREQ;
                                end
                            end
                            S_TXACK: state_q <= (cmd_q == CmdRead) ? S_RREQ : S_IDLE;
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (eoc_i && !eoc_prev_q) eoc_pend_q <= 1'b1;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = tx_valid_q;
    assign obi_req_o    = req_q;
    assign obi_addr_o   = obi_addr_q;
    assign obi_we_o     = we_q;
    assign obi_be_o     = 4'hF;
    assign obi_wdata_o  = obi_wdata_q;
    assign exec_valid_o = exec_valid_q;
    assign exec_addr_o  = exec_addr_q;
    assign rx_overrun_o = overrun_q;
endmodule

// File: tb/tb_uart_dbg_responder.sv
// Bench for uart_dbg_responder: host-side command sequences against an OBI memory
// model and a command-level scoreboard of expected tx bytes and bus transactions.
module tb_uart_dbg_responder;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        obi_req_o, obi_gnt_i = 1'b0, obi_we_o;
    logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i = '0, exec_addr_o;
    logic [3:0]  obi_be_o;
    logic        obi_rvalid_i = 1'b0, obi_err_i = 1'b0;
    logic        exec_valid_o, eoc_i = 1'b0, rx_overrun_o;

    always #5 clk = ~clk;

    uart_dbg_responder #(.TimeoutCycles(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
        .exec_valid_o(exec_valid_o), .exec_addr_o(exec_addr_o), .eoc_i(eoc_i),
        .rx_overrun_o(rx_overrun_o)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Unwritten memory returns a fixed function of the address.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // ---------------- tx sink with random stalls ----------------
    logic [7:0] txq[$];
    bit         hold = 1'b0;
    logic [7:0] hold_data;
    always @(negedge clk) begin
        if (rst_i) begin
            tx_ready_i = 1'b0;
            hold = 1'b0;
        end else begin
            if (hold) chk("tx_stable", 32'({tx_valid_o, tx_data_o}), 32'({1'b1, hold_data}));
            tx_ready_i = ($urandom_range(0, 1) == 1);
            hold = 1'b0;
            if (tx_valid_o) begin
                if (tx_ready_i) txq.push_back(tx_data_o);
                else begin hold = 1'b1; hold_data = tx_data_o; end
            end
        end
    end

    // ---------------- OBI memory ----------------
    typedef struct { logic [31:0] addr; logic [31:0] data; logic we; } txn_t;
    txn_t        logq[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int txn_cnt = 0, rsp_cnt = 0, err_txn = -1, force_dly = -1, dly = 0;
    bit pend = 1'b0, perr = 1'b0, gnt_block = 1'b0;
    logic [31:0] prdata;
    always @(negedge clk) begin
        obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_gnt_i = 1'b0;
        if (rst_i) pend = 1'b0;
        else if (pend) begin
            if (dly == 0) begin
                obi_rvalid_i = 1'b1; obi_err_i = perr; obi_rdata_i = prdata;
                pend = 1'b0; rsp_cnt++;
            end else dly--;
        end else if (obi_req_o && !gnt_block && $urandom_range(0, 2) != 0) begin
            obi_gnt_i = 1'b1;
            chk("obi_align", 32'(obi_addr_o[1:0]), 32'd0);
            chk("obi_be", 32'(obi_be_o), 32'hF);
            perr = (txn_cnt == err_txn);
            logq.push_back('{obi_addr_o, obi_wdata_o, obi_we_o});
            if (obi_we_o) begin
                if (!perr) mem[obi_addr_o] = obi_wdata_o;
                prdata = 32'h0;
            end else prdata = mem.exists(obi_addr_o) ? mem[obi_addr_o] : dflt(obi_addr_o);
            txn_cnt++;
            pend = 1'b1;
            dly = (force_dly >= 0) ? force_dly : $urandom_range(0, 2);
        end
    end

    // ---------------- exec pulse monitor ----------------
    int ex_hi = 0, ex_rise = 0;
    bit ex_prev = 1'b0;
    logic [31:0] ex_addr = '0;
    always @(negedge clk) begin
        if (exec_valid_o) begin
            ex_hi++; ex_addr = exec_addr_o;
            if (!ex_prev) ex_rise++;
        end
        ex_prev = exec_valid_o;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- host tasks / reference model ----------------
    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 1)) @(posedge clk);
        @(posedge clk); #1 rx_valid_i = 1'b1; rx_data_i = b;
        @(posedge clk); #1 rx_valid_i = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a, input bit with_n, input logic [7:0] n8);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (with_n) send_byte(n8);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (txq.size() < n && k < 60 * n + 500) begin @(posedge clk); k++; end
        repeat (20) @(posedge clk);
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int k = 0;
        while (rsp_cnt < target && k < 200) begin @(posedge clk); k++; end
        if (rsp_cnt < target) chk({tag, "_rsp_timeout"}, 32'(rsp_cnt), 32'(target));
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic do_write(input logic [31:0] a, input int n, input logic [31:0] d[$],
                            input int err_word, input string tag);
        logic [31:0] am = a & ~32'h3;
        int base = txn_cnt;
        int nexp = (err_word < 0) ? n : err_word + 1;
        txq.delete(); logq.delete();
        err_txn = (err_word < 0) ? -1 : base + err_word;
        send_hdr(8'h12, a, 1'b1, n[7:0]);
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) send_byte(d[w][8*b +: 8]);
            if (err_word < 0 || w <= err_word) wait_rsp(rsp_cnt + 1, tag);
        end
        wait_tx(1);
        chk({tag, "_txcnt"}, 32'(txq.size()), 32'd1);
        chk({tag, "_resp"}, 32'(txq[0]), (err_word < 0) ? 32'h06 : 32'h15);
        chk({tag, "_ntxn"}, 32'(logq.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < logq.size(); i++) begin
            chk({tag, "_waddr"}, logq[i].addr, am + 32'(4 * i));
            chk({tag, "_wdata"}, logq[i].data, d[i]);
            chk({tag, "_we"}, 32'(logq[i].we), 32'd1);
        end
        for (int i = 0; i < n; i++)
            if (err_word < 0 || i < err_word) ref_mem[am + 32'(4 * i)] = d[i];
        err_txn = -1;
    endtask

    task automatic do_read(input logic [31:0] a, input int n, input int err_word,
                           input bit eoc_tail, input string tag);
        logic [31:0] am = a & ~32'h3;
        logic [7:0]  exp[$];
        logic [31:0] w;
        int nw = (err_word < 0) ? n : err_word;
        int nexp = (err_word < 0) ? n : err_word + 1;
        txq.delete(); logq.delete();
        err_txn = (err_word < 0) ? -1 : txn_cnt + err_word;
        exp.push_back(8'h06);
        for (int i = 0; i < nw; i++) begin
            w = ref_rd(am + 32'(4 * i));
            for (int b = 0; b < 4; b++) exp.push_back(w[8*b +: 8]);
        end
        exp.push_back((err_word < 0) ? 8'h04 : 8'h15);
        if (eoc_tail) exp.push_back(8'h14);
        send_hdr(8'h11, a, 1'b1, n[7:0]);
        wait_tx(exp.size());
        chk({tag, "_txcnt"}, 32'(txq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < txq.size(); i++)
            chk({tag, "_txbyte"}, 32'(txq[i]), 32'(exp[i]));
        chk({tag, "_ntxn"}, 32'(logq.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < logq.size(); i++) begin
            chk({tag, "_raddr"}, logq[i].addr, am + 32'(4 * i));
            chk({tag, "_we"}, 32'(logq[i].we), 32'd0);
        end
        err_txn = -1;
    endtask

    task automatic do_exec(input logic [31:0] a, input string tag);
        txq.delete(); ex_hi = 0; ex_rise = 0;
        send_hdr(8'h13, a, 1'b0, 8'h00);
        wait_tx(1);
        chk({tag, "_txcnt"}, 32'(txq.size()), 32'd1);
        chk({tag, "_ack"}, 32'(txq[0]), 32'h06);
        chk({tag, "_pulses"}, 32'(ex_rise), 32'd1);
        chk({tag, "_width"}, 32'(ex_hi), 32'd1);
        chk({tag, "_addr"}, ex_addr, a & ~32'h3);
        chk({tag, "_held"}, exec_addr_o, a & ~32'h3);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
        chk({tag, "_req"}, 32'(obi_req_o), 32'd0);
        chk({tag, "_we"}, 32'(obi_we_o), 32'd0);
        chk({tag, "_addr"}, obi_addr_o, 32'd0);
        chk({tag, "_wdata"}, obi_wdata_o, 32'd0);
        chk({tag, "_be"}, 32'(obi_be_o), 32'hF);
        chk({tag, "_exec_valid"}, 32'(exec_valid_o), 32'd0);
        chk({tag, "_exec_addr"}, exec_addr_o, 32'd0);
        chk({tag, "_overrun"}, 32'(rx_overrun_o), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d[$];
        int b0, k;

        repeat (3) @(posedge clk);
        #1 check_reset_outs("reset");
        rst_i = 1'b0;

        d = '{32'h1234_5678, 32'hDEAD_BEEF};
        do_write(32'h1000_0000, 2, d, -1, "wr2");
        do_read(32'h1000_0000, 2, -1, 1'b0, "rd2");
        do_exec(32'h1000_0080, "exec");

        d = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        do_write(32'h1000_0100, 3, d, 1, "wr_err");
        do_read(32'h1000_0000, 2, 0, 1'b0, "rd_err");

        // EOC raised mid-READ is reported only after EOT.
        fork
            do_read(32'h1000_0000, 4, -1, 1'b1, "rd_eoc");
            begin
                k = 0;
                while (txq.size() < 3 && k < 500) begin @(posedge clk); k++; end
                #1 eoc_i = 1'b1;
            end
        join
        eoc_i = 1'b0;
        repeat (5) @(posedge clk);
        txq.delete();
        #1 eoc_i = 1'b1;
        wait_tx(1);
        chk("eoc_idle_cnt", 32'(txq.size()), 32'd1);
        chk("eoc_idle_byte", 32'(txq[0]), 32'h14);
        eoc_i = 1'b0;

        // Timeouts in ADDR and WDATA, unknown command ignored.
        txq.delete(); b0 = txn_cnt;
        send_byte(8'h11);
        repeat (TMO + 5) @(posedge clk);
        send_hdr(8'h12, 32'h1000_0300, 1'b1, 8'd1);
        send_byte(8'hAA); send_byte(8'hBB);
        repeat (TMO + 5) @(posedge clk);
        send_byte(8'h55); send_byte(8'h00);
        repeat (20) @(posedge clk);
        chk("tmo_notx", 32'(txq.size()), 32'd0);
        chk("tmo_notxn", 32'(txn_cnt - b0), 32'd0);
        do_exec(32'h2000_0007, "exec_after_tmo");

        // Byte during RRSP is dropped and flagged.
        chk("overrun_clear", 32'(rx_overrun_o), 32'd0);
        force_dly = 8; b0 = txn_cnt;
        fork
            do_read(32'h1000_0000, 1, -1, 1'b0, "rd_ovr");
            begin
                k = 0;
                while (txn_cnt == b0 && k < 500) begin @(posedge clk); k++; end
                send_byte(8'h13);
            end
        join
        force_dly = -1;
        chk("overrun_set", 32'(rx_overrun_o), 32'd1);

        // Reset while a write request waits for grant.
        gnt_block = 1'b1;
        send_hdr(8'h12, 32'h1000_0200, 1'b1, 8'd2);
        for (int i = 0; i < 4; i++) send_byte(8'h77);
        repeat (3) @(posedge clk);
        #1 chk("wreq_pending", 32'(obi_req_o), 32'd1);
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 check_reset_outs("midrst");
        rst_i = 1'b0; gnt_block = 1'b0;
        do_read(32'h1000_0000, 2, -1, 1'b0, "rd_after_rst");

        // Address wrap and N=0 (256 words).
        d = '{32'hCAFE_0001, 32'hCAFE_0002};
        do_write(32'hFFFF_FFFD, 2, d, -1, "wr_wrap");
        do_read(32'hFFFF_FFFC, 2, -1, 1'b0, "rd_wrap");
        do_read(32'h1000_0000, 256, -1, 1'b0, "rd_256");

        // Randomized commands.
        for (int it = 0; it < 8; it++) begin
            logic [31:0] a;
            int n, e;
            a = 32'h3000_0000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            n = $urandom_range(1, 4);
            e = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            if ($urandom_range(0, 1) == 1) begin
                d.delete();
                for (int i = 0; i < n; i++) d.push_back($urandom);
                do_write(a, n, d, e, "rnd_wr");
            end else begin
                do_read(a, n, e, 1'b0, "rnd_rd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
